// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: shared definitions for the NoC flit receive endpoint.
//   Flit layout (131 bits): [1:0] type, [129:2] payload, [130] flit-present mark.
//   Also holds the flit type encoding and the receiver FSM state encoding.
package noc_flit_pkg;

  localparam int FLIT_W      = 131;
  localparam int PAYLOAD_W   = 128;
  localparam int TYPE_LSB    = 0;
  localparam int PAYLOAD_LSB = 2;
  localparam int MARK_BIT    = 130;

  typedef enum logic [1:0] {
    T_SINGLE = 2'b00,
    T_HEAD   = 2'b01,
    T_BODY   = 2'b10,
    T_TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: synchronous FIFO of DEPTH entries holding {payload, sop, eop}.
//   clk, rst   : rising-edge clock, synchronous active-low reset
//   push, din  : write one entry (caller only pushes while ready=1)
//   pop        : remove the head entry (ignored while empty)
//   dout       : head entry, forced to zero while empty
//   empty      : no entries held
//   ready      : registered "not full", low during reset
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 130
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      ready <= (count_nxt != CW'(DEPTH));
    end
  end

  // Storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/noc_flit_receiver.sv
// noc_flit_receiver: receive-side NoC endpoint. Accepts 131-bit flits with a
// valid/ready handshake, checks per-packet type sequencing, buffers payloads
// in flit_fifo and presents them with start/end-of-packet markers.
//   clk, rst            : rising-edge clock, synchronous active-low reset
//   i_data, i_valid     : flit from router; o_ready = FIFO not full
//   o_payload/o_sop/o_eop/o_valid, i_ack : consumer side of the FIFO head
//   o_pkt_count         : completed packets, saturating
//   o_err_count, o_err  : dropped flits (saturating) and one-cycle drop pulse
// Build option: NOC_RX_CHECK_EN enables drop rules and the sequencing FSM;
// without it every accepted flit is pushed and sop/eop come from the type.
module noc_flit_receiver
  import noc_flit_pkg::*;
#(
  parameter int xcord = 0,
  parameter int ycord = 0,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_W-1:0]    i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_sop,
  output logic                 o_eop,
  output logic                 o_valid,
  input  logic                 i_ack,
  output logic [15:0]          o_pkt_count,
  output logic [15:0]          o_err_count,
  output logic                 o_err
);

  // Tile coordinates are identification only.
  localparam int UNUSED_TILE = xcord + ycord;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  flit_type_e             ftype;
  logic [PAYLOAD_W-1:0]   payload;
  logic                   accept;
  logic                   push;
  logic                   sop;
  logic                   eop;
  logic                   pkt_inc;
  logic                   empty;
  logic                   pop;
  logic [PAYLOAD_W+1:0]   head;
  logic [15:0]            pkt_count_p1;

  assign ftype   = flit_type_e'(i_data[TYPE_LSB +: 2]);
  assign payload = i_data[PAYLOAD_LSB +: PAYLOAD_W];
  assign accept  = i_valid && o_ready;
  assign pop     = !empty && i_ack;

`ifdef NOC_RX_CHECK_EN
  rx_state_e   state;
  rx_state_e   state_nxt;
  logic        drop;
  logic        err_p1;
  logic [15:0] err_count_p1;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    sop       = 1'b0;
    eop       = 1'b0;
    pkt_inc   = 1'b0;
    drop      = 1'b0;
    if (accept) begin
      if (!i_data[MARK_BIT]) begin
        drop = 1'b1;
      end else if (state == ST_IDLE) begin
        case (ftype)
          T_SINGLE: begin push = 1'b1; sop = 1'b1; eop = 1'b1; pkt_inc = 1'b1; end
          T_HEAD:   begin push = 1'b1; sop = 1'b1; state_nxt = ST_IN_PKT; end
          default:  drop = 1'b1;
        endcase
      end else begin
        case (ftype)
          T_BODY: push = 1'b1;
          T_TAIL: begin push = 1'b1; eop = 1'b1; pkt_inc = 1'b1; state_nxt = ST_IDLE; end
          // An unexpected start abandons the partial packet already queued.
          default: begin drop = 1'b1; state_nxt = ST_IDLE; end
        endcase
      end
    end
  end

  // ---- p1: error pulse and drop counter ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_p1       <= 1'b0;
      err_count_p1 <= '0;
    end else begin
      err_p1       <= drop;
      err_count_p1 <= sat_inc(err_count_p1, drop);
    end
  end

  assign o_err       = err_p1;
  assign o_err_count = err_count_p1;
`else
  logic unused_mark;

  assign unused_mark = i_data[MARK_BIT];
  assign push        = accept;
  assign sop         = (ftype == T_SINGLE) || (ftype == T_HEAD);
  assign eop         = (ftype == T_SINGLE) || (ftype == T_TAIL);
  assign pkt_inc     = accept && eop;
  assign o_err       = 1'b0;
  assign o_err_count = '0;
`endif

  // ---- p1: completed packet counter ----
  always_ff @(posedge clk) begin
    if (!rst) pkt_count_p1 <= '0;
    else      pkt_count_p1 <= sat_inc(pkt_count_p1, pkt_inc);
  end

  assign o_pkt_count = pkt_count_p1;

  flit_fifo #(
    .DEPTH (DEPTH),
    .W     (PAYLOAD_W + 2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({payload, sop, eop}),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .ready (o_ready)
  );

  assign o_valid   = !empty;
  assign o_payload = head[PAYLOAD_W+1:2];
  assign o_sop     = head[1];
  assign o_eop     = head[0];

endmodule

// File: tb/tb_noc_flit_receiver.sv
module tb_noc_flit_receiver;

  logic         clk = 1'b0;
  logic         rst;
  logic [130:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] o_payload;
  logic         o_sop;
  logic         o_eop;
  logic         o_valid;
  logic         i_ack;
  logic [15:0]  o_pkt_count;
  logic [15:0]  o_err_count;
  logic         o_err;

  int n_vec = 0;
  int n_bad = 0;

  noc_flit_receiver #(.xcord(0), .ycord(0), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_payload   (o_payload),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .o_valid     (o_valid),
    .i_ack       (i_ack),
    .o_pkt_count (o_pkt_count),
    .o_err_count (o_err_count),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one flit for one cycle, then sample just after the edge.
  task automatic send(input logic [1:0] t, input logic m, input logic [127:0] p);
    i_data  = {m, p, t};
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_ack = 1'b0; i_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",     o_ready, 0);
    check("rst_valid",     o_valid, 0);
    check("rst_payload",   o_payload, 0);
    check("rst_sop_eop",   {o_sop, o_eop}, 0);
    check("rst_pkt_count", o_pkt_count, 0);
    check("rst_err_count", o_err_count, 0);
    check("rst_err",       o_err, 0);
    rst = 1'b1;
    tick();
    check("ready_after_rst", o_ready, 1);

    // Single-flit packet
    i_ack = 1'b1;
    send(2'b00, 1'b1, 128'hcb0000000eafac43_800000004b200000);
    check("single_valid",   o_valid, 1);
    check("single_payload", o_payload, 128'hcb0000000eafac43_800000004b200000);
    check("single_sop_eop", {o_sop, o_eop}, 2'b11);
    check("single_pkt",     o_pkt_count, 1);
    check("single_errcnt",  o_err_count, 0);
    tick();
    check("single_drained", o_valid, 0);

    // Three-flit packet, back to back at full throughput
    send(2'b01, 1'b1, 128'd1);
    check("head_payload", o_payload, 1);
    check("head_sop_eop", {o_sop, o_eop}, 2'b10);
    send(2'b10, 1'b1, 128'd2);
    check("body_payload", o_payload, 2);
    check("body_sop_eop", {o_sop, o_eop}, 2'b00);
    send(2'b11, 1'b1, 128'd3);
    check("tail_payload", o_payload, 3);
    check("tail_sop_eop", {o_sop, o_eop}, 2'b01);
    check("pkt_after_3flit", o_pkt_count, 2);
    tick();
    check("3flit_drained", o_valid, 0);

    // Backpressure: DEPTH+1 singles offered with i_ack low
    i_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_data  = {1'b1, 128'(10 + k), 2'b00};
      i_valid = 1'b1;
      tick();
    end
    check("bp_full_ready", o_ready, 0);
    i_data = {1'b1, 128'd14, 2'b00};
    tick();
    check("bp_held_ready", o_ready, 0);
    check("bp_head_first", o_payload, 10);
    i_ack = 1'b1;
    tick();
    i_ack = 1'b0;
    check("bp_ready_back", o_ready, 1);
    check("bp_head_after_pop", o_payload, 11);
    tick();
    i_valid = 1'b0;
    check("bp_fifth_accepted", o_ready, 0);
    i_ack = 1'b1;
    for (int k = 11; k <= 14; k++) begin
      check("bp_order", o_payload, 128'(k));
      tick();
    end
    check("bp_drained", o_valid, 0);
    check("bp_pkt_count", o_pkt_count, 7);

    // Protocol errors: body in IDLE, then head, then single mid-packet
    send(2'b10, 1'b1, 128'd20);
`ifdef NOC_RX_CHECK_EN
    check("perr_body_err",   o_err, 1);
    check("perr_body_valid", o_valid, 0);
    check("perr_body_cnt",   o_err_count, 1);
    send(2'b01, 1'b1, 128'd21);
    check("perr_head_err",     o_err, 0);
    check("perr_head_payload", o_payload, 21);
    check("perr_head_sop_eop", {o_sop, o_eop}, 2'b10);
    send(2'b00, 1'b1, 128'd22);
    check("perr_single_err",   o_err, 1);
    check("perr_single_valid", o_valid, 0);
    check("perr_err_count",    o_err_count, 2);
    send(2'b00, 1'b1, 128'd23);
    check("perr_idle_single",  o_payload, 23);
    check("perr_idle_sop_eop", {o_sop, o_eop}, 2'b11);
    check("perr_pkt_count",    o_pkt_count, 8);
    check("perr_err_cleared",  o_err, 0);
`else
    check("perr_body_err",     o_err, 0);
    check("perr_body_payload", o_payload, 20);
    check("perr_body_sop_eop", {o_sop, o_eop}, 2'b00);
    send(2'b01, 1'b1, 128'd21);
    check("perr_head_payload", o_payload, 21);
    check("perr_head_sop_eop", {o_sop, o_eop}, 2'b10);
    send(2'b00, 1'b1, 128'd22);
    check("perr_single_payload", o_payload, 22);
    check("perr_single_sop_eop", {o_sop, o_eop}, 2'b11);
    send(2'b00, 1'b1, 128'd23);
    check("perr_pkt_count", o_pkt_count, 9);
    check("perr_err_count", o_err_count, 0);
`endif
    tick();
    check("perr_drained", o_valid, 0);

    // Mark bit clear
    send(2'b00, 1'b0, 128'd30);
`ifdef NOC_RX_CHECK_EN
    check("mark_err",       o_err, 1);
    check("mark_err_count", o_err_count, 3);
    check("mark_valid",     o_valid, 0);
    check("mark_pkt_count", o_pkt_count, 8);
`else
    check("mark_err",       o_err, 0);
    check("mark_valid",     o_valid, 1);
    check("mark_payload",   o_payload, 30);
    check("mark_pkt_count", o_pkt_count, 10);
`endif
    tick();

    // Reset in the middle of a packet
    i_ack = 1'b0;
    send(2'b01, 1'b1, 128'd40);
    send(2'b10, 1'b1, 128'd41);
    check("mid_valid_before", o_valid, 1);
    rst = 1'b0;
    tick();
    check("mid_rst_ready",   o_ready, 0);
    check("mid_rst_valid",   o_valid, 0);
    check("mid_rst_payload", o_payload, 0);
    check("mid_rst_sop_eop", {o_sop, o_eop}, 0);
    check("mid_rst_pkt",     o_pkt_count, 0);
    check("mid_rst_errcnt",  o_err_count, 0);
    check("mid_rst_err",     o_err, 0);
    rst = 1'b1;
    tick();
    check("mid_ready_back", o_ready, 1);
    i_ack = 1'b1;
    send(2'b00, 1'b1, 128'd42);
    check("post_rst_payload", o_payload, 42);
    check("post_rst_sop_eop", {o_sop, o_eop}, 2'b11);
    check("post_rst_pkt",     o_pkt_count, 1);
    tick();
    check("post_rst_drained", o_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
